ex_stage_mc: RTL and testbench
==============================

// Module: ex_stage_mc
// PURPOSE
//  Parametrised multi-cycle EX stage for the 5-stage MIPS pipeline; sits between ID/EX and MEM.
//  Single-cycle ALU ops retire in 1 cycle; MUL/DIV run on an iterative unit (XLEN cycles) and stall ID via ex_ready.
//  Owns the EX/MEM register with a valid bit. Full MEM/WB forwarding on rs/rt with correct priority. Synchronous flush.
// PARAMETERS
//  XLEN     32  datapath width (power of 2, >=8)
//  REG_AW   5   register-index width
// PORTS
//  clk            in   1        clock
//  rst            in   1        asynchronous reset, active-high
//  flush          in   1        kill in-flight op / insert bubble
//  id_valid       in   1        ID/EX holds a valid instruction
//  ex_ready       out  1        EX can accept; =(state==IDLE)
//  data_1/data_2  in   XLEN     regfile values of rs/rt
//  rs, rt, rd     in   REG_AW   operand/dest indices
//  imm            in   XLEN     sign-extended immediate; funct = imm[5:0]
//  ex             in   4        [3]=RegDst, [2:1]=ALU_op, [0]=ALUSrc
//  m_ex / wb_ex   in   3 / 2    MEM/WB controls; wb_ex[0]=RegWrite
//  wb_rd          in   REG_AW   WB-stage destination
//  wb_reg_write   in   1        WB-stage RegWrite
//  wb_data        in   XLEN     WB-stage write-back value
//  mem_valid      out  1        EX/MEM holds a valid instruction
//  res, zero      out  XLEN/1   registered result; zero=(result==0)
//  write_register out  REG_AW   RegDst ? rd : rt
//  write_data     out  XLEN     forwarded rt value (store data)
//  m_mem / wb_mem out  3 / 2    registered controls; forced 0 on bubble
// BEHAVIOUR
//  Reset: all registered outputs 0, FSM=IDLE, cnt=0, so ex_ready=1 while rst high.
//  Forwarding (per source s in {rs,rt}): MEM if mem_valid&wb_mem[0]&write_register!=0&write_register==s -> res;
//   else WB if wb_reg_write&wb_rd!=0&wb_rd==s -> wb_data; else data_1/data_2. MEM beats WB.
//  op_1=fwd_rs; op_2=ex[0]?imm:fwd_rt; write_data=fwd_rt (not imm).
//  Decode: ALU_op 0 ADD, 1 SUB, 2 funct {3 SRA,32 ADD,34 SUB,36 AND,37 OR,38 XOR,39 NOR,42 SLT,0x18 MUL,0x1A DIV}.
//   ALU_op 3 or unknown funct: result 0.
//  Arithmetic: ADD/SUB wrap mod 2^XLEN. SLT signed -> 1/0. SRA = $signed(op_2)>>>op_1[log2(XLEN)-1:0].
//   MUL = low XLEN bits of unsigned product. DIV = unsigned quotient; divisor 0 -> all-ones.
//  Accept: cycle where id_valid&ex_ready&~flush.
//  Single-cycle op accepted at cycle t: EX/MEM loaded at end of t, mem_valid=1 at t+1.
//  FSM IDLE->MUL_BUSY/DIV_BUSY on accept of MUL/DIV: latch operands, rd-select, m_ex, wb_ex; cnt=0.
//   EX/MEM gets bubble meanwhile. BUSY: one shift-add / restoring-subtract step per cycle, cnt++.
//   At the edge where cnt==XLEN-1: load result+latched controls, mem_valid=1, ->IDLE.
//   ex_ready=0 cycles t+1..t+XLEN; mem_valid=1 at t+XLEN+1.
//  No accept (id_valid=0, BUSY, or flush): EX/MEM loads bubble.
//   mem_valid=0, m_mem=0, wb_mem=0; res/write_register don't-care but zero = 0.
//  flush: priority over accept and completion. Aborts BUSY -> IDLE next edge; no result retires.
//  Async rst mid-operation: immediate return to reset state; partial result discarded.
// TESTING
//  ADD: data_1=5,data_2=7,ex=4'b1100,funct 32,rd=4 -> next cycle res=12,zero=0,write_register=4,mem_valid=1.
//  Forward: ADD r3=1+2 then SUB r5=r3-r3 while WB writes r3=99 -> SUB uses MEM value 3: res=0, zero=1.
//  MUL 7*6 (XLEN=32): ex_ready low 32 cycles, res=42 exactly 33 cycles after accept;
//   DIV 100/7 -> 14; DIV 5/0 -> 0xFFFFFFFF.
//  SLT -1<1 -> 1; SRA op_2=0x80000000, op_1=4 -> 0xF8000000; ALU_op=3 -> res=0.
//  DIV accepted, flush at busy cycle 10 -> mem_valid never rises for it; ex_ready=1 next cycle, next ADD retires normally.
//  Assert rst mid-MUL (no clock edge) -> outputs 0, ex_ready=1 immediately; after release a new op completes correctly.

Source files
------------

// File: rtl/ex_stage_mc_if.sv
// ----------------------------------------------------------------------------
// ex_stage_mc_if
// Bundles the ID/EX -> EX -> EX/MEM signals of the multi-cycle EX stage.
//   master : the pipeline around EX (drives ID/EX fields, flush and WB-stage
//            forwarding info, observes ex_ready and the EX/MEM register)
//   slave  : the EX stage itself (ex_stage_mc)
// Signals:
//   flush, id_valid, ex_ready            pipeline control / handshake
//   data_1, data_2, rs, rt, rd, imm      operands and register indices
//   ex, m_ex, wb_ex                      EX / MEM / WB control fields
//   wb_rd, wb_reg_write, wb_data         WB-stage forwarding source
//   mem_valid, res, zero, write_register,
//   write_data, m_mem, wb_mem            EX/MEM register contents
// ----------------------------------------------------------------------------
interface ex_stage_mc_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic                flush;
    logic                id_valid;
    logic                ex_ready;
    logic [XLEN-1:0]     data_1;
    logic [XLEN-1:0]     data_2;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic [REG_AW-1:0]   rd;
    logic [XLEN-1:0]     imm;
    logic [3:0]          ex;
    logic [2:0]          m_ex;
    logic [1:0]          wb_ex;
    logic [REG_AW-1:0]   wb_rd;
    logic                wb_reg_write;
    logic [XLEN-1:0]     wb_data;
    logic                mem_valid;
    logic [XLEN-1:0]     res;
    logic                zero;
    logic [REG_AW-1:0]   write_register;
    logic [XLEN-1:0]     write_data;
    logic [2:0]          m_mem;
    logic [1:0]          wb_mem;

    modport master (
        output flush, id_valid, data_1, data_2, rs, rt, rd, imm,
               ex, m_ex, wb_ex, wb_rd, wb_reg_write, wb_data,
        input  ex_ready, mem_valid, res, zero, write_register,
               write_data, m_mem, wb_mem
    );

    modport slave (
        input  flush, id_valid, data_1, data_2, rs, rt, rd, imm,
               ex, m_ex, wb_ex, wb_rd, wb_reg_write, wb_data,
        output ex_ready, mem_valid, res, zero, write_register,
               write_data, m_mem, wb_mem
    );
endinterface

// File: rtl/ex_stage_mc.sv
// ----------------------------------------------------------------------------
// ex_stage_mc
// Multi-cycle EX stage of a 5-stage MIPS pipeline. Single-cycle ALU ops
// retire into the EX/MEM register one cycle after acceptance; MUL and DIV run
// on a shared iterative unit (one shift-add / restoring-subtract step per
// cycle, XLEN steps) and hold ex_ready low while busy. Operands are forwarded
// from the EX/MEM register (highest priority) or the WB stage.
// Ports:
//   clk  clock
//   rst  asynchronous reset, active high
//   bus  ex_stage_mc_if.slave (handshake, operands, controls, EX/MEM outputs)
// ----------------------------------------------------------------------------
module ex_stage_mc #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst,
    ex_stage_mc_if.slave   bus
);

    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN);

    // XLEN is a power of two, so the final step index XLEN-1 is all ones.
    localparam logic [CNT_W-1:0] LAST_CNT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [5:0] F_SRA = 6'd3;
    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_XOR = 6'd38;
    localparam logic [5:0] F_NOR = 6'd39;
    localparam logic [5:0] F_SLT = 6'd42;
    localparam logic [5:0] F_MUL = 6'h18;
    localparam logic [5:0] F_DIV = 6'h1A;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_t;

    // FSM and iterative-unit state
    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [XLEN-1:0]     op_a_r;      // MUL: shifting multiplicand / DIV: dividend->quotient
    logic [XLEN-1:0]     op_b_r;      // MUL: shifting multiplier   / DIV: divisor
    logic [XLEN-1:0]     acc_r;       // MUL: partial product       / DIV: remainder
    logic [REG_AW-1:0]   wreg_lat_r;
    logic [XLEN-1:0]     wdata_lat_r;
    logic [2:0]          m_lat_r;
    logic [1:0]          wb_lat_r;

    // EX/MEM register
    logic                mem_valid_r;
    logic [XLEN-1:0]     res_r;
    logic                zero_r;
    logic [REG_AW-1:0]   wreg_r;
    logic [XLEN-1:0]     wdata_r;
    logic [2:0]          m_mem_r;
    logic [1:0]          wb_mem_r;

    // Combinational signals
    logic [XLEN-1:0]     fwd_rs_s;
    logic [XLEN-1:0]     fwd_rt_s;
    logic [XLEN-1:0]     op_1_s;
    logic [XLEN-1:0]     op_2_s;
    logic [SHW-1:0]      shamt_s;
    logic [1:0]          alu_op_s;
    logic [5:0]          funct_s;
    logic [XLEN-1:0]     alu_res_s;
    logic                is_mul_s;
    logic                is_div_s;
    logic                accept_s;
    logic                last_s;
    logic [REG_AW-1:0]   wsel_s;
    logic [XLEN-1:0]     mul_acc_nxt_s;
    logic [XLEN:0]       div_rem_sh_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_rem_nxt_s;
    logic [XLEN-1:0]     div_quo_nxt_s;
    logic                retire_s;
    logic [XLEN-1:0]     ret_res_s;
    logic [REG_AW-1:0]   ret_wreg_s;
    logic [XLEN-1:0]     ret_wdata_s;
    logic [2:0]          ret_m_s;
    logic [1:0]          ret_wb_s;

    // Forwarding source pick: EX/MEM result beats WB data; register 0 never forwards.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [REG_AW-1:0] src,
        input logic [XLEN-1:0]   rf_val,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_rd,
        input logic [XLEN-1:0]   mem_val,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_val
    );
        if (mem_en && (mem_rd != {REG_AW{1'b0}}) && (mem_rd == src)) begin
            return mem_val;
        end else if (wb_en && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == src)) begin
            return wb_val;
        end else begin
            return rf_val;
        end
    endfunction

    assign alu_op_s = bus.ex[2:1];
    assign funct_s  = bus.imm[5:0];
    assign accept_s = bus.id_valid & (state_r == IDLE) & ~bus.flush;
    assign last_s   = (cnt_r == LAST_CNT);
    assign wsel_s   = bus.ex[3] ? bus.rd : bus.rt;

    // Operand forwarding and ALUSrc selection.
    always_comb begin
        fwd_rs_s = fwd_pick(bus.rs, bus.data_1, mem_valid_r & wb_mem_r[0], wreg_r, res_r,
                            bus.wb_reg_write, bus.wb_rd, bus.wb_data);
        fwd_rt_s = fwd_pick(bus.rt, bus.data_2, mem_valid_r & wb_mem_r[0], wreg_r, res_r,
                            bus.wb_reg_write, bus.wb_rd, bus.wb_data);
        op_1_s   = fwd_rs_s;
        if (bus.ex[0]) begin
            op_2_s = bus.imm;
        end else begin
            op_2_s = fwd_rt_s;
        end
        shamt_s  = op_1_s[SHW-1:0];
    end

    // Single-cycle ALU and MUL/DIV detection.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        is_mul_s  = 1'b0;
        is_div_s  = 1'b0;
        case (alu_op_s)
            2'd0: alu_res_s = op_1_s + op_2_s;
            2'd1: alu_res_s = op_1_s - op_2_s;
            2'd2: begin
                case (funct_s)
                    F_SRA: alu_res_s = $signed(op_2_s) >>> shamt_s;
                    F_ADD: alu_res_s = op_1_s + op_2_s;
                    F_SUB: alu_res_s = op_1_s - op_2_s;
                    F_AND: alu_res_s = op_1_s & op_2_s;
                    F_OR:  alu_res_s = op_1_s | op_2_s;
                    F_XOR: alu_res_s = op_1_s ^ op_2_s;
                    F_NOR: alu_res_s = ~(op_1_s | op_2_s);
                    F_SLT: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_1_s) < $signed(op_2_s))};
                    F_MUL: is_mul_s  = 1'b1;
                    F_DIV: is_div_s  = 1'b1;
                    default: alu_res_s = {XLEN{1'b0}};
                endcase
            end
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        if (op_b_r[0]) begin
            mul_acc_nxt_s = acc_r + op_a_r;
        end else begin
            mul_acc_nxt_s = acc_r;
        end
        div_rem_sh_s = {acc_r, op_a_r[XLEN-1]};
        div_ge_s     = (div_rem_sh_s >= {1'b0, op_b_r});
        // The remainder stays below the divisor, so the difference fits in XLEN bits.
        if (div_ge_s) begin
            div_rem_nxt_s = div_rem_sh_s[XLEN-1:0] - op_b_r;
        end else begin
            div_rem_nxt_s = div_rem_sh_s[XLEN-1:0];
        end
        div_quo_nxt_s = {op_a_r[XLEN-2:0], div_ge_s};
    end

    // Selects what (if anything) retires into EX/MEM this cycle.
    always_comb begin
        retire_s    = 1'b0;
        ret_res_s   = {XLEN{1'b0}};
        ret_wreg_s  = {REG_AW{1'b0}};
        ret_wdata_s = {XLEN{1'b0}};
        ret_m_s     = 3'd0;
        ret_wb_s    = 2'd0;
        if (bus.flush) begin
            retire_s = 1'b0;
        end else if (accept_s && !(is_mul_s || is_div_s)) begin
            retire_s    = 1'b1;
            ret_res_s   = alu_res_s;
            ret_wreg_s  = wsel_s;
            ret_wdata_s = fwd_rt_s;
            ret_m_s     = bus.m_ex;
            ret_wb_s    = bus.wb_ex;
        end else if ((state_r == MUL_BUSY) && last_s) begin
            retire_s    = 1'b1;
            ret_res_s   = mul_acc_nxt_s;
            ret_wreg_s  = wreg_lat_r;
            ret_wdata_s = wdata_lat_r;
            ret_m_s     = m_lat_r;
            ret_wb_s    = wb_lat_r;
        end else if ((state_r == DIV_BUSY) && last_s) begin
            retire_s    = 1'b1;
            ret_res_s   = div_quo_nxt_s;
            ret_wreg_s  = wreg_lat_r;
            ret_wdata_s = wdata_lat_r;
            ret_m_s     = m_lat_r;
            ret_wb_s    = wb_lat_r;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Control FSM and iterative MUL/DIV datapath; flush aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_a_r      <= {XLEN{1'b0}};
            op_b_r      <= {XLEN{1'b0}};
            acc_r       <= {XLEN{1'b0}};
            wreg_lat_r  <= {REG_AW{1'b0}};
            wdata_lat_r <= {XLEN{1'b0}};
            m_lat_r     <= 3'd0;
            wb_lat_r    <= 2'd0;
        end else if (bus.flush) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && (is_mul_s || is_div_s)) begin
                        state_r     <= is_mul_s ? MUL_BUSY : DIV_BUSY;
                        cnt_r       <= {CNT_W{1'b0}};
                        op_a_r      <= op_1_s;
                        op_b_r      <= op_2_s;
                        acc_r       <= {XLEN{1'b0}};
                        wreg_lat_r  <= wsel_s;
                        wdata_lat_r <= fwd_rt_s;
                        m_lat_r     <= bus.m_ex;
                        wb_lat_r    <= bus.wb_ex;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL_BUSY: begin
                    if (last_s) begin
                        state_r <= IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        acc_r  <= mul_acc_nxt_s;
                        op_a_r <= op_a_r << 1;
                        op_b_r <= op_b_r >> 1;
                        cnt_r  <= cnt_r + CNT_ONE;
                    end
                end
                DIV_BUSY: begin
                    if (last_s) begin
                        state_r <= IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        acc_r  <= div_rem_nxt_s;
                        op_a_r <= div_quo_nxt_s;
                        cnt_r  <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // EX/MEM pipeline register: loads a retiring result or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_r <= 1'b0;
            res_r       <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
            wreg_r      <= {REG_AW{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            m_mem_r     <= 3'd0;
            wb_mem_r    <= 2'd0;
        end else if (retire_s) begin
            mem_valid_r <= 1'b1;
            res_r       <= ret_res_s;
            zero_r      <= (ret_res_s == {XLEN{1'b0}});
            wreg_r      <= ret_wreg_s;
            wdata_r     <= ret_wdata_s;
            m_mem_r     <= ret_m_s;
            wb_mem_r    <= ret_wb_s;
        end else begin
            mem_valid_r <= 1'b0;
            res_r       <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
            wreg_r      <= {REG_AW{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            m_mem_r     <= 3'd0;
            wb_mem_r    <= 2'd0;
        end
    end

    assign bus.ex_ready       = (state_r == IDLE);
    assign bus.mem_valid      = mem_valid_r;
    assign bus.res            = res_r;
    assign bus.zero           = zero_r;
    assign bus.write_register = wreg_r;
    assign bus.write_data     = wdata_r;
    assign bus.m_mem          = m_mem_r;
    assign bus.wb_mem         = wb_mem_r;

endmodule

// File: tb/tb_ex_stage_mc.sv
// ----------------------------------------------------------------------------
// tb_ex_stage_mc
// Directed-vector bench for ex_stage_mc (XLEN=32). Each issued instruction
// pushes its hand-computed EX/MEM contents and retire cycle into a queue; an
// independent monitor pops and compares whenever mem_valid is seen.
// ----------------------------------------------------------------------------
module tb_ex_stage_mc;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [2:0]  m;
        logic [1:0]  wb;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    ex_stage_mc_if #(.XLEN(32), .REG_AW(5)) ifc ();

    ex_stage_mc #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waits for ex_ready, presents one instruction for one cycle, optionally
    // records its expected EX/MEM contents, retiring lat cycles later.
    task automatic issue(input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] rd_i,
                         input logic [31:0] imm_i, input logic [3:0] ex_i,
                         input logic [2:0] m_i, input logic [1:0] wb_i,
                         input logic [4:0] wrd, input logic wwe, input logic [31:0] wdat,
                         input logic push, input logic [31:0] eres, input logic [4:0] ewreg,
                         input logic [31:0] ewd, input int lat);
        int n;
        n = 0;
        while (!ifc.ex_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ifc.ex_ready) begin
            checks++;
            errors++;
            $display("FAIL ex_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
        end
        ifc.data_1       = d1;
        ifc.data_2       = d2;
        ifc.rs           = rs_i;
        ifc.rt           = rt_i;
        ifc.rd           = rd_i;
        ifc.imm          = imm_i;
        ifc.ex           = ex_i;
        ifc.m_ex         = m_i;
        ifc.wb_ex        = wb_i;
        ifc.wb_rd        = wrd;
        ifc.wb_reg_write = wwe;
        ifc.wb_data      = wdat;
        ifc.id_valid     = 1'b1;
        if (push) begin
            sbq.push_back('{res: eres, zero: (eres == 32'd0), wreg: ewreg, wdata: ewd,
                            m: m_i, wb: wb_i, cyc: cyc + lat});
        end
        @(posedge clk); #1;
        ifc.id_valid     = 1'b0;
        ifc.wb_reg_write = 1'b0;
    endtask

    // Monitor: compares every retirement against the scoreboard, bubbles against zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.mem_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got res 0x%08h expected no retirement (cycle %0d)",
                             ifc.res, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("res",            ifc.res,                    mon_e.res);
                    chk("zero",           {31'd0, ifc.zero},          {31'd0, mon_e.zero});
                    chk("write_register", {27'd0, ifc.write_register}, {27'd0, mon_e.wreg});
                    chk("write_data",     ifc.write_data,             mon_e.wdata);
                    chk("m_mem",          {29'd0, ifc.m_mem},         {29'd0, mon_e.m});
                    chk("wb_mem",         {30'd0, ifc.wb_mem},        {30'd0, mon_e.wb});
                    chk("retire_cycle",   cyc,                        mon_e.cyc);
                end
            end else begin
                chk("bubble_zero", {31'd0, ifc.zero},   32'd0);
                chk("bubble_m",    {29'd0, ifc.m_mem},  32'd0);
                chk("bubble_wb",   {30'd0, ifc.wb_mem}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst              = 1'b1;
        ifc.flush        = 1'b0;
        ifc.id_valid     = 1'b0;
        ifc.data_1       = 32'd0;
        ifc.data_2       = 32'd0;
        ifc.rs           = 5'd0;
        ifc.rt           = 5'd0;
        ifc.rd           = 5'd0;
        ifc.imm          = 32'd0;
        ifc.ex           = 4'd0;
        ifc.m_ex         = 3'd0;
        ifc.wb_ex        = 2'd0;
        ifc.wb_rd        = 5'd0;
        ifc.wb_reg_write = 1'b0;
        ifc.wb_data      = 32'd0;
        #1;
        chk("rst_ex_ready",  {31'd0, ifc.ex_ready},  32'd1);
        chk("rst_mem_valid", {31'd0, ifc.mem_valid}, 32'd0);
        chk("rst_res",       ifc.res,                32'd0);
        chk("rst_wreg",      {27'd0, ifc.write_register}, 32'd0);
        chk("rst_wb_mem",    {30'd0, ifc.wb_mem},    32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD via funct: 5+7 -> 12, rd selected
        issue(32'd5, 32'd7, 5'd1, 5'd2, 5'd4, 32'd32, 4'b1100, 3'b010, 2'b10,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd12, 5'd4, 32'd7, 1);
        // r3 = 1+2, then SUB r5 = r3-r3 with MEM beating WB (r3=99)
        issue(32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 32'd32, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd3, 5'd3, 32'd2, 1);
        issue(32'd50, 32'd60, 5'd3, 5'd3, 5'd5, 32'd0, 4'b1010, 3'b101, 2'b01,
              5'd3, 1'b1, 32'd99, 1'b1, 32'd0, 5'd5, 32'd3, 1);
        // WB forwarding on rs: r6=40 from WB, +2 -> 42
        issue(32'd0, 32'd2, 5'd6, 5'd2, 5'd7, 32'd32, 4'b1100, 3'b000, 2'b00,
              5'd6, 1'b1, 32'd40, 1'b1, 32'd42, 5'd7, 32'd2, 1);
        // ALUSrc immediate, RegDst=0 -> rt; store data is rt value, not imm
        issue(32'd5, 32'd77, 5'd8, 5'd9, 5'd10, 32'd100, 4'b0001, 3'b001, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd105, 5'd9, 32'd77, 1);
        // writes to r0 never forward (neither from MEM nor WB)
        issue(32'd1, 32'd1, 5'd1, 5'd2, 5'd0, 32'd32, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd2, 5'd0, 32'd1, 1);
        issue(32'd10, 32'd20, 5'd0, 5'd0, 5'd11, 32'd32, 4'b1100, 3'b000, 2'b00,
              5'd0, 1'b1, 32'd555, 1'b1, 32'd30, 5'd11, 32'd20, 1);
        // SLT -1 < 1, SRA, ALU_op 3, SUB/AND/NOR funct, unknown funct
        issue(32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 5'd12, 32'd42, 4'b1100, 3'b000, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd1, 5'd12, 32'd1, 1);
        issue(32'd4, 32'h8000_0000, 5'd1, 5'd2, 5'd13, 32'd3, 4'b1100, 3'b000, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'hF800_0000, 5'd13, 32'h8000_0000, 1);
        issue(32'd9, 32'd9, 5'd1, 5'd2, 5'd14, 32'd32, 4'b1110, 3'b000, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd0, 5'd14, 32'd9, 1);
        issue(32'd5, 32'd7, 5'd1, 5'd2, 5'd15, 32'd34, 4'b1100, 3'b000, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, 5'd15, 32'd7, 1);
        issue(32'h0000_F0F0, 32'h0000_FF00, 5'd1, 5'd2, 5'd16, 32'd36, 4'b1100, 3'b000, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'h0000_F000, 5'd16, 32'h0000_FF00, 1);
        issue(32'h0000_F0F0, 32'h0000_FF00, 5'd1, 5'd2, 5'd17, 32'd39, 4'b1100, 3'b000, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_000F, 5'd17, 32'h0000_FF00, 1);
        issue(32'd3, 32'd4, 5'd1, 5'd2, 5'd18, 32'd1, 4'b1100, 3'b000, 2'b00,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd0, 5'd18, 32'd4, 1);

        // MUL 7*6: ex_ready low for exactly 32 cycles, retire 33 cycles after accept
        issue(32'd7, 32'd6, 5'd1, 5'd2, 5'd19, 32'h18, 4'b1100, 3'b011, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd42, 5'd19, 32'd6, 33);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (ifc.ex_ready) break;
            n++;
        end
        chk("mul_busy_cycles", n, 32'd32);
        // MUL wrap, DIV 100/7, DIV by zero
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd20, 32'h18, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd1, 5'd20, 32'hFFFF_FFFF, 33);
        issue(32'd100, 32'd7, 5'd1, 5'd2, 5'd21, 32'h1A, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd14, 5'd21, 32'd7, 33);
        issue(32'd5, 32'd0, 5'd1, 5'd2, 5'd22, 32'h1A, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 5'd22, 32'd0, 33);

        // DIV flushed at busy cycle 10: never retires, next ADD retires normally
        issue(32'd100, 32'd3, 5'd1, 5'd2, 5'd23, 32'h1A, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd0, 0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        ifc.flush = 1'b1;
        @(posedge clk); #1;
        ifc.flush = 1'b0;
        chk("flush_ex_ready", {31'd0, ifc.ex_ready}, 32'd1);
        issue(32'd2, 32'd3, 5'd1, 5'd2, 5'd24, 32'd32, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd5, 5'd24, 32'd3, 1);
        repeat (40) begin
            @(posedge clk); #1;
        end

        // Async reset in the middle of a MUL, away from any clock edge
        issue(32'd9, 32'd9, 5'd1, 5'd2, 5'd25, 32'h18, 4'b1100, 3'b000, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd0, 0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ex_ready",  {31'd0, ifc.ex_ready},  32'd1);
        chk("arst_mem_valid", {31'd0, ifc.mem_valid}, 32'd0);
        chk("arst_res",       ifc.res,                32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(32'd3, 32'd5, 5'd1, 5'd2, 5'd26, 32'h18, 4'b1100, 3'b100, 2'b01,
              5'd0, 1'b0, 32'd0, 1'b1, 32'd15, 5'd26, 32'd5, 33);
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
